// File: rtl/skinny_masked_pkg.sv
// -----------------------------------------------------------------------------
// skinny_masked_pkg
// Shared constants and the sequencer state encoding for the 2-share masked
// SKINNY datapath.
//   SHARE_W          width of one share of a byte
//   RND_W            fresh randomness consumed by one S-box evaluation
//   SBOX8_HPC2_LAT   cycles the S-box needs with stable operands
//   sbox_seq_state_t sequencer state encoding (ST_* constants)
// -----------------------------------------------------------------------------
package skinny_masked_pkg;

    localparam int SHARE_W        = 8;
    localparam int RND_W          = 16;
    localparam int SBOX8_HPC2_LAT = 8;

    typedef logic [2:0] sbox_seq_state_t;

    localparam sbox_seq_state_t ST_IDLE = 3'd0;
    localparam sbox_seq_state_t ST_RAND = 3'd1;
    localparam sbox_seq_state_t ST_HOLD = 3'd2;
    localparam sbox_seq_state_t ST_DONE = 3'd3;
    localparam sbox_seq_state_t ST_CLR  = 3'd4;

endpackage

// File: rtl/skinny_sbox8_hpc2_seq_sbox.sv
// -----------------------------------------------------------------------------
// skinny_sbox8_hpc2_1_str_non_pipelined_de
// 2-share masked SKINNY 8-bit S-box. Four MIX layers, each holding two masked
// NOR gates built from HPC2 AND gadgets; the bit permutation and final swap
// are linear and applied to each share separately. Gadget inner terms are
// registered on the falling edge, products on the rising edge, so operands
// must stay stable for several cycles (the sequencer guarantees this).
//   clk          clock (both edges used)
//   si0_i/si1_i  input shares
//   r_i          fresh randomness: [7:0] gadget masks, [15:8] output remask
//   bo0_o/bo1_o  output shares
// -----------------------------------------------------------------------------
module skinny_sbox8_hpc2_1_str_non_pipelined_de
    import skinny_masked_pkg::*;
(
    input  logic               clk,
    input  logic [SHARE_W-1:0] si0_i,
    input  logic [SHARE_W-1:0] si1_i,
    input  logic [RND_W-1:0]   r_i,
    output logic [SHARE_W-1:0] bo0_o,
    output logic [SHARE_W-1:0] bo1_o
);

    function automatic logic [7:0] bit_perm(input logic [7:0] x);
        return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
    endfunction

    function automatic logic [7:0] bit_swap(input logic [7:0] x);
        return {x[7:3], x[1], x[2], x[0]};
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_layer
        logic [7:0] xi0, xi1, m0, m1, xo0, xo1;
        logic [1:0] na0, na1, nb0, nb1, rr, c0, c1;
        logic [1:0] t01_q, t10_q, p00_q, p11_q, q0_q, q1_q, s0_q, s1_q;

        if (k == 0) begin : g_first
            assign xi0 = si0_i;
            assign xi1 = si1_i;
        end else begin : g_next
            assign xi0 = g_layer[k-1].xo0;
            assign xi1 = g_layer[k-1].xo1;
        end

        // NOR(a,b) = (~a)&(~b); inverting share 0 inverts the shared value.
        // Lane 1 feeds bit 4 from bits 7/6, lane 0 feeds bit 0 from bits 3/2.
        assign na0 = ~{xi0[7], xi0[3]};
        assign na1 =  {xi1[7], xi1[3]};
        assign nb0 = ~{xi0[6], xi0[2]};
        assign nb1 =  {xi1[6], xi1[2]};
        assign rr  = r_i[2*k +: 2];

        always_ff @(negedge clk) begin
            t01_q <= nb1 ^ rr;
            t10_q <= nb0 ^ rr;
        end

        always_ff @(posedge clk) begin
            p00_q <= na0 & nb0;
            p11_q <= na1 & nb1;
            q0_q  <= ~na0 & rr;
            q1_q  <= ~na1 & rr;
            s0_q  <= na0 & t01_q;
            s1_q  <= na1 & t10_q;
        end

        // The rr terms cancel across shares, leaving (na0^na1)&(nb0^nb1).
        assign c0 = p00_q ^ q0_q ^ s0_q;
        assign c1 = p11_q ^ q1_q ^ s1_q;

        assign m0 = xi0 ^ {3'b000, c0[1], 3'b000, c0[0]};
        assign m1 = xi1 ^ {3'b000, c1[1], 3'b000, c1[0]};

        if (k < 3) begin : g_perm
            assign xo0 = bit_perm(m0);
            assign xo1 = bit_perm(m1);
        end else begin : g_last
            assign xo0 = m0;
            assign xo1 = m1;
        end
    end

    // Same mask on both shares: refreshes the sharing without changing the value.
    assign bo0_o = bit_swap(g_layer[3].xo0) ^ r_i[15:8];
    assign bo1_o = bit_swap(g_layer[3].xo1) ^ r_i[15:8];

endmodule

// File: rtl/skinny_sbox8_hpc2_seq.sv
// -----------------------------------------------------------------------------
// skinny_sbox8_hpc2_seq
// Sequencer around the masked S-box: takes a shared byte, fetches 16 bits of
// fresh randomness, holds all operands stable for LAT cycles, captures the
// shared result and offers it downstream. Operand registers are wiped after
// each result (CLR_EN) so consecutive operands never toggle against each other.
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready/in_s0/in_s1  input share handshake
//   rnd_req/rnd_ack/rnd_data       randomness handshake
//   out_valid/out_ready/out_s0/s1  result share handshake
//   busy                           operation in progress
// -----------------------------------------------------------------------------
module skinny_sbox8_hpc2_seq
    import skinny_masked_pkg::*;
#(
    parameter int LAT    = SBOX8_HPC2_LAT,
    parameter bit CLR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_s0,
    input  logic [7:0]  in_s1,
    output logic        rnd_req,
    input  logic        rnd_ack,
    input  logic [15:0] rnd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_s0,
    output logic [7:0]  out_s1,
    output logic        busy
);

    localparam int CNT_W = $clog2(LAT);

    if (LAT < SBOX8_HPC2_LAT) begin : g_lat_check
        $error("LAT must be at least %0d", SBOX8_HPC2_LAT);
    end

    sbox_seq_state_t    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHARE_W-1:0] si0_q, si0_d, si1_q, si1_d;
    logic [RND_W-1:0]   r_q, r_d;
    logic [SHARE_W-1:0] out_s0_q, out_s0_d, out_s1_q, out_s1_d;
    logic [SHARE_W-1:0] bo0, bo1;

    skinny_sbox8_hpc2_1_str_non_pipelined_de u_sbox (
        .clk   (clk),
        .si0_i (si0_q),
        .si1_i (si1_q),
        .r_i   (r_q),
        .bo0_o (bo0),
        .bo1_o (bo1)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        si0_d    = si0_q;
        si1_d    = si1_q;
        r_d      = r_q;
        out_s0_d = out_s0_q;
        out_s1_d = out_s1_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    si0_d   = in_s0;
                    si1_d   = in_s1;
                    state_d = ST_RAND;
                end
            end
            ST_RAND: begin
                if (rnd_ack) begin
                    r_d     = rnd_data;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    out_s0_d = bo0;
                    out_s1_d = bo1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    // Result registers are wiped on acceptance in both modes.
                    out_s0_d = '0;
                    out_s1_d = '0;
                    state_d  = CLR_EN ? ST_CLR : ST_IDLE;
                end
            end
            ST_CLR: begin
                si0_d    = '0;
                si1_d    = '0;
                r_d      = '0;
                out_s0_d = '0;
                out_s1_d = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            si0_q    <= '0;
            si1_q    <= '0;
            r_q      <= '0;
            out_s0_q <= '0;
            out_s1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            si0_q    <= si0_d;
            si1_q    <= si1_d;
            r_q      <= r_d;
            out_s0_q <= out_s0_d;
            out_s1_q <= out_s1_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign rnd_req   = (state_q == ST_RAND);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_s0    = out_s0_q;
    assign out_s1    = out_s1_q;

endmodule

// File: doc/skinny_sbox8_hpc2_seq.md
# skinny_sbox8_hpc2_seq

Sequencer for the 2-share HPC2 masked SKINNY 8-bit S-box (`skinny_sbox8_hpc2_1_str_non_pipelined_de`). It accepts one shared byte over a valid/ready handshake and fetches 16 bits of fresh randomness over a req/ack handshake. It holds both operands register-stable for the full S-box latency, captures the shared result and presents it over a valid/ready handshake. Between operations it clears the operand registers so no unmasked transition leaks. It sits between the round datapath of the masked SKINNY core and the S-box instance.

## Interface
Parameters:
- `LAT`, 8: S-box hold cycles. Values below 8 are illegal; an elaboration-time check enforces this.
- `CLR_EN`, 1: when 1, insert the one-cycle operand-clear state after each result.

Ports:
- `clk`  in  1  clock. Internal registers use posedge; the S-box instance uses both edges.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input shares offered.
- `in_ready`  out  1  block can accept input.
- `in_s0`, `in_s1`  in  8 each  input shares 0 and 1.
- `rnd_req`  out  1  request for randomness.
- `rnd_ack`  in  1  `rnd_data` valid this cycle.
- `rnd_data`  in  16  fresh mask bits, routed to S-box `r`.
- `out_valid`  out  1  result shares valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_s0`, `out_s1`  out  8 each  result shares 0 and 1.
- `busy`  out  1  state is not IDLE.

## Operation
FSM states: IDLE, RAND, HOLD, DONE, CLR.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `in_s0`/`in_s1` into the `si0`/`si1` registers, then go to RAND.
- **RAND**
  - `rnd_req`=1.
  - On `rnd_ack`: latch `rnd_data` into the `r` register, load `cnt`=LAT-1, then go to HOLD.
  - `rnd_ack` in any other state is ignored.
- **HOLD**
  - `si0`, `si1` and `r` are frozen.
  - `cnt` decrements each cycle.
  - When `cnt`==0: capture S-box `bo0`/`bo1` into the `out_s0`/`out_s1` registers, then go to DONE.
- **DONE**
  - `out_valid`=1; outputs are stable until accepted.
  - On `out_ready`: go to CLR if `CLR_EN`, otherwise to IDLE.
- **CLR**
  - Zero `si0`, `si1`, `r`, `out_s0` and `out_s1`, then go to IDLE.
  - When `CLR_EN`=0, `out_s0`/`out_s1` are still zeroed on acceptance; `si0`/`si1`/`r` keep their values until the next load.

Rules:
- `in_ready`, `rnd_req` and `out_valid` are mutually exclusive and decoded from state only; no combinational path from inputs.
- Input shares are never recombined; share 0 and share 1 are kept in separate registers at every stage.
- Counter width is `$clog2(LAT)`; `cnt` does not wrap, because it is reloaded on every RAND→HOLD transition.

## Timing
- **Reset**
  - State returns to IDLE.
  - `cnt`, `si0`, `si1`, `r`, `out_s0` and `out_s1` are cleared to 0.
  - `in_ready`=1 after release; `rnd_req`, `out_valid` and `busy` are 0.
  - Reset asserted mid-operation aborts immediately; no partial result is emitted.
- **Latency**
  - Input accepted at edge E0; RAND from E0.
  - `rnd_ack` sampled at edge E1 (earliest E0+1).
  - HOLD spans edges E1..E1+LAT; capture happens at E1+LAT.
  - `out_valid` rises after E1+LAT.
  - Minimum input-to-output is LAT+1 cycles.
- **Throughput**
  - One operation per LAT+3+`CLR_EN` cycles at minimum: accept, rand, LAT hold, done, clear.
  - The next `in_ready` comes 1+`CLR_EN` cycles after the `out_ready` handshake.
- **Boundary cases**
  - `out_ready` held high continuously: `out_valid` is a one-cycle pulse.
  - `rnd_ack` held high: consumed once only; RAND lasts one cycle.
  - `in_valid` while busy: ignored, since `in_ready`=0.
  - `rnd_data` changing during HOLD has no effect, because `r` is registered.

## Structure
- Shared package `skinny_masked_pkg`: state encoding `sbox_seq_state_t`, the `SBOX8_HPC2_LAT`=8 constant and the share width constant.
- One sub-module: instance `u_sbox` of `skinny_sbox8_hpc2_1_str_non_pipelined_de`, driven only by the `si0`/`si1`/`r` registers.
- The FSM, counter and registers live in the top module.

## Test plan
- **Unshared zero:** `in_s0`=0x5A, `in_s1`=0x5A, `rnd_ack` in the next cycle with `rnd_data`=0xBEEF.
  - `out_s0`^`out_s1`=0x65.
  - `out_valid` exactly 9 cycles after the accept edge.
- **All-ones:** `in_s0`=0x0F, `in_s1`=0xF0, `rnd_data`=0x1234.
  - `out_s0`^`out_s1`=0xFF.
  - Repeating with `rnd_data`=0xA5C3 gives the same XOR but different `out_s0`.
- **Randomness stall:** `rnd_ack` delayed 5 cycles.
  - `rnd_req` stays high for 6 cycles.
  - `out_valid` 14 cycles after accept; `in_ready`=0 throughout.
- **Output backpressure:** `out_ready`=0 for 10 cycles.
  - `out_valid` and the outputs are stable.
  - After acceptance with `CLR_EN`=1: `si0`/`si1`/`r`=0 for one cycle, then `in_ready`=1.
- **Reset mid-HOLD:** assert `rst` at `cnt`=3.
  - All outputs go to reset values asynchronously.
  - After release, a new operation completes correctly.
- **Back-to-back:** 256 random inputs with `out_ready`=1 and immediate `rnd_ack`.
  - Every unmasked result matches the SKINNY S8 table.
  - Period is 12 cycles per byte.
